trace_capture_buffer: RTL

TRACE_CAPTURE_BUFFER -- requirements
Module: trace_capture_buffer

---
 rtl/trace_capture_buffer_pkg.sv | 23 ++
 rtl/trace_half_tracker.sv | 64 ++++++
 rtl/trace_capture_buffer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/trace_capture_buffer_pkg.sv
// Shared encodings for the trace capture buffer: the issue FSM and the
// per-half ping-pong lifecycle.
package trace_capture_buffer_pkg;

  typedef enum logic [1:0] {
    I_IDLE  = 2'd0,
    I_START = 2'd1,
    I_WAIT  = 2'd2
  } issue_state_t;

  typedef enum logic [1:0] {
    H_FREE     = 2'd0,
    H_FILLING  = 2'd1,
    H_SEALED   = 2'd2,
    H_DRAINING = 2'd3
  } half_state_t;

  // A half holds undrained data once sealed and until its job completes.
  function automatic logic half_busy(input half_state_t s);
    return (s == H_SEALED) || (s == H_DRAINING);
  endfunction

endpackage

// File: rtl/trace_half_tracker.sv
// Tracks the lifecycle and sealed word count of the two buffer halves and
// picks the oldest sealed half for the next burst job.  Halves are always
// sealed alternately, so a toggling issue pointer yields oldest-first order.
module trace_half_tracker
  import trace_capture_buffer_pkg::*;
#(
  parameter int BufferAddrWidth = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic                       wr_half,
  input  logic                       seal_en,
  input  logic                       seal_half,
  input  logic [BufferAddrWidth-1:0] seal_size,
  input  logic                       issue_en,
  input  logic                       free_en,
  input  logic                       free_half,
  output logic [1:0]                 half0_state,
  output logic [1:0]                 half1_state,
  output logic                       issue_avail,
  output logic                       issue_half,
  output logic [BufferAddrWidth-1:0] issue_size
);

  half_state_t                state_q [2];
  logic [BufferAddrWidth-1:0] size_q  [2];
  logic                       next_q;

  // Per-half lifecycle; free and seal of different halves both apply.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q[0] <= H_FREE;
      state_q[1] <= H_FREE;
      next_q     <= 1'b0;
    end else begin
      for (int h = 0; h < 2; h++) begin
        if (free_en && free_half == 1'(h))
          state_q[h] <= H_FREE;
        else if (seal_en && seal_half == 1'(h))
          state_q[h] <= H_SEALED;
        else if (issue_en && next_q == 1'(h))
          state_q[h] <= H_DRAINING;
        else if (wr_en && wr_half == 1'(h) && state_q[h] == H_FREE)
          state_q[h] <= H_FILLING;
      end
      if (issue_en)
        next_q <= ~next_q;
    end
  end

  // Word count captured at seal time; pure data, no reset needed.
  always_ff @(posedge clk) begin
    if (seal_en)
      size_q[seal_half] <= seal_size;
  end

  assign half0_state = state_q[0];
  assign half1_state = state_q[1];
  assign issue_half  = next_q;
  assign issue_avail = (state_q[next_q] == H_SEALED);
  assign issue_size  = size_q[next_q];

endmodule

// File: rtl/trace_capture_buffer.sv
// Ping-pong trace capture: words fill one half of the buffer RAM while the
// other half is handed to an AXI write engine as a burst job.  A flush seals
// a partial half and acknowledges once everything has drained.
module trace_capture_buffer
  import trace_capture_buffer_pkg::*;
#(
  parameter int BufferDataWidth = 32,
  parameter int BufferAddrWidth = 10,
  parameter int AXIAddrWidth    = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [AXIAddrWidth-1:0]    axi_base,
  input  logic                       trace_valid,
  input  logic [BufferDataWidth-1:0] trace_data,
  output logic                       trace_ready,
  input  logic                       flush,
  output logic                       flush_ack,
  output logic [BufferAddrWidth-1:0] buffer_addr,
  output logic [BufferDataWidth-1:0] buffer_wdata,
  output logic                       buffer_ce,
  output logic                       buffer_we,
  output logic                       start_valid,
  input  logic                       start_ready,
  output logic [BufferAddrWidth-1:0] data_ptr,
  output logic [BufferAddrWidth-1:0] data_size,
  output logic [AXIAddrWidth-1:0]    axi_offset,
  input  logic                       done_valid,
  output logic                       done_ready
);

  localparam int H = 2 ** (BufferAddrWidth - 1);
  localparam logic [BufferAddrWidth-1:0] HALF_WORDS = BufferAddrWidth'(H);
  localparam int WORD_BYTES = BufferDataWidth / 8;

  issue_state_t               state_q, state_d;
  logic                       fill_half_q;
  logic [BufferAddrWidth-1:0] fill_count_q;
  logic                       flush_pending_q;

  logic [1:0]                 half0_raw, half1_raw;
  half_state_t                s0, s1, cur_st, oth_st;
  logic                       open, accept, flush_take, seal_en, do_switch, drained;
  logic [BufferAddrWidth-1:0] eff_count;
  logic                       issue_en, issue_avail, issue_half, free_en;
  logic [BufferAddrWidth-1:0] issue_size;
  logic [AXIAddrWidth-1:0]    job_bytes;

  trace_half_tracker #(
    .BufferAddrWidth(BufferAddrWidth)
  ) u_tracker (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (accept),
    .wr_half    (fill_half_q),
    .seal_en    (seal_en),
    .seal_half  (fill_half_q),
    .seal_size  (eff_count),
    .issue_en   (issue_en),
    .free_en    (free_en),
    .free_half  (data_ptr[BufferAddrWidth-1]),
    .half0_state(half0_raw),
    .half1_state(half1_raw),
    .issue_avail(issue_avail),
    .issue_half (issue_half),
    .issue_size (issue_size)
  );

  // Capture/seal/flush decisions; a flush seals whatever the accepted word
  // (if any) brings the count to, so a word+flush cycle yields one job.
  always_comb begin
    s0          = half_state_t'(half0_raw);
    s1          = half_state_t'(half1_raw);
    cur_st      = fill_half_q ? s1 : s0;
    oth_st      = fill_half_q ? s0 : s1;
    open        = (cur_st == H_FREE) || (cur_st == H_FILLING);
    trace_ready = !reset && open && !flush_pending_q;
    accept      = trace_valid && trace_ready;
    eff_count   = fill_count_q + {{(BufferAddrWidth-1){1'b0}}, accept};
    flush_take  = !reset && flush && !flush_pending_q;
    seal_en     = !reset && open &&
                  ((accept && eff_count == HALF_WORDS) ||
                   (flush_take && eff_count != '0));
    do_switch   = (seal_en || !open) && (oth_st == H_FREE);
    drained     = !half_busy(s0) && !half_busy(s1) && (state_q == I_IDLE);
    flush_ack   = !reset && flush_pending_q && drained;
  end

  assign buffer_ce    = accept;
  assign buffer_we    = accept;
  assign buffer_addr  = {fill_half_q, fill_count_q[BufferAddrWidth-2:0]};
  assign buffer_wdata = trace_data;

  // Fill position and flush bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_half_q     <= 1'b0;
      fill_count_q    <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      if (do_switch) begin
        fill_half_q  <= ~fill_half_q;
        fill_count_q <= '0;
      end else begin
        fill_count_q <= eff_count;
      end
      if (flush_ack)
        flush_pending_q <= 1'b0;
      else if (flush_take)
        flush_pending_q <= 1'b1;
    end
  end

  // Issue FSM next-state and handshake outputs.
  always_comb begin
    state_d     = state_q;
    start_valid = 1'b0;
    done_ready  = 1'b0;
    issue_en    = 1'b0;
    free_en     = 1'b0;
    case (state_q)
      I_IDLE: begin
        if (issue_avail) begin
          issue_en = 1'b1;
          state_d  = I_START;
        end
      end
      I_START: begin
        start_valid = 1'b1;
        if (start_ready)
          state_d = I_WAIT;
      end
      I_WAIT: begin
        done_ready = 1'b1;
        if (done_valid) begin
          free_en = 1'b1;
          state_d = I_IDLE;
        end
      end
      default: state_d = I_IDLE;
    endcase
    if (reset) begin
      start_valid = 1'b0;
      done_ready  = 1'b0;
      issue_en    = 1'b0;
      free_en     = 1'b0;
    end
  end

  // Issue FSM state register.
  always_ff @(posedge clk) begin
    if (reset)
      state_q <= I_IDLE;
    else
      state_q <= state_d;
  end

  // Job descriptor latched on entry to I_START and held through it.
  always_ff @(posedge clk) begin
    if (issue_en) begin
      data_ptr  <= {issue_half, {(BufferAddrWidth-1){1'b0}}};
      data_size <= issue_size;
    end
  end

  assign job_bytes = AXIAddrWidth'(data_size) * AXIAddrWidth'(WORD_BYTES);

  // AXI destination advances past each accepted job, wrapping naturally.
  always_ff @(posedge clk) begin
    if (reset)
      axi_offset <= axi_base;
    else if (start_valid && start_ready)
      axi_offset <= axi_offset + job_bytes;
  end

endmodule
